uart_tx_fifo: RTL and testbench

//  Byte buffer and launch controller sitting directly upstream of the UART transmitter.

---
 rtl/uart_tx_fifo.sv | 164 ++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// ============================================================================
// Module   : uart_tx_fifo
// Purpose  : Byte FIFO that launches one tx_start per byte into a UART
//            transmitter, waiting for tx_done_tick between launches.
//            Optional macro UART_TX_FIFO_LEVEL_EN adds level/almost_full.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_fifo #(
  parameter int DBIT   = 8,
  parameter int ADDR_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en,
  input  logic [DBIT-1:0] wr_data,
  output logic            full,
  output logic            empty,
  output logic            overflow,
  output logic            tx_start,
  output logic [DBIT-1:0] tx_din,
  input  logic            tx_done_tick,
  output logic            busy
`ifdef UART_TX_FIFO_LEVEL_EN
  ,
  output logic [ADDR_W:0] level,
  output logic            almost_full
`endif
);

  localparam logic [ADDR_W:0] c_depth     = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] c_af_thresh = c_depth - (ADDR_W+1)'(2);
  localparam logic [ADDR_W:0] c_one       = (ADDR_W+1)'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2
  } state_t;

  logic [DBIT-1:0]   r_mem [c_depth];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_full;
  logic              r_empty;
  logic              r_overflow;
  logic              r_tx_start;
  logic [DBIT-1:0]   r_tx_din;
  logic              r_busy;
  state_t            r_state;

  state_t            w_state_next;
  logic              w_push;
  logic              w_pop;
  logic [ADDR_W:0]   w_count_next;

  // Full is judged on the pre-edge count, so a same-cycle pop never frees a slot.
  assign w_push = wr_en && !r_full;

  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!r_empty) begin
          w_state_next = ST_LAUNCH;
          w_pop        = 1'b1;
        end
      end
      ST_LAUNCH: begin
        w_state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (tx_done_tick) begin
          if (!r_empty) begin
            w_state_next = ST_LAUNCH;
            w_pop        = 1'b1;
          end else begin
            w_state_next = ST_IDLE;
          end
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + c_one;
      2'b01:   w_count_next = r_count - c_one;
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_overflow <= 1'b0;
      r_tx_start <= 1'b0;
      r_tx_din   <= '0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_count    <= w_count_next;
      r_full     <= (w_count_next == c_depth);
      r_empty    <= (w_count_next == '0);
      r_overflow <= wr_en && r_full;
      r_tx_start <= (w_state_next == ST_LAUNCH);
      r_busy     <= (w_state_next != ST_IDLE);
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      // Pop only ever happens on a launch; tx_din then holds until the next one.
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_tx_din <= r_mem[r_rd_ptr];
      end
    end
  end

  assign full     = r_full;
  assign empty    = r_empty;
  assign overflow = r_overflow;
  assign tx_start = r_tx_start;
  assign tx_din   = r_tx_din;
  assign busy     = r_busy;

`ifdef UART_TX_FIFO_LEVEL_EN
  logic [ADDR_W:0] r_level;
  logic            r_almost_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level       <= '0;
      r_almost_full <= 1'b0;
    end else begin
      r_level       <= w_count_next;
      r_almost_full <= (w_count_next >= c_af_thresh);
    end
  end

  assign level       = r_level;
  assign almost_full = r_almost_full;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
// ============================================================================
// Module   : tb_uart_tx_fifo
// Purpose  : Self-checking bench for uart_tx_fifo against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_fifo;

  localparam int DBIT   = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            wr_en = 1'b0;
  logic [DBIT-1:0] wr_data = '0;
  logic            tx_done_tick = 1'b0;
  logic            full, empty, overflow, tx_start, busy;
  logic [DBIT-1:0] tx_din;
`ifdef UART_TX_FIFO_LEVEL_EN
  logic [ADDR_W:0] level;
  logic            almost_full;
`endif

  uart_tx_fifo #(.DBIT(DBIT), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .full         (full),
    .empty        (empty),
    .overflow     (overflow),
    .tx_start     (tx_start),
    .tx_din       (tx_din),
    .tx_done_tick (tx_done_tick),
    .busy         (busy)
`ifdef UART_TX_FIFO_LEVEL_EN
    ,
    .level        (level),
    .almost_full  (almost_full)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: queue of stored bytes plus the launch/ack handshake view.
  logic [7:0] m_q[$];
  logic       m_busy, m_start, m_ovf;
  logic [7:0] m_din;
  bit         m_launch, m_acc, m_nbusy;
  bit         seen_start, done_since;
  logic [7:0] launched[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      m_q.delete();
      m_busy = 0; m_start = 0; m_ovf = 0; m_din = 8'h00;
      seen_start = 0; done_since = 0;
    end
    check("full",     32'(full),     32'(m_q.size() == DEPTH));
    check("empty",    32'(empty),    32'(m_q.size() == 0));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("tx_start", 32'(tx_start), 32'(m_start));
    check("tx_din",   32'(tx_din),   32'(m_din));
    check("busy",     32'(busy),     32'(m_busy));
`ifdef UART_TX_FIFO_LEVEL_EN
    check("level",       32'(level),       32'(m_q.size()));
    check("almost_full", 32'(almost_full), 32'(m_q.size() >= DEPTH - 2));
`endif
    if (rst_n && tx_start === 1'b1) begin
      launched.push_back(tx_din);
      if (seen_start) check("start_needs_done", 32'(done_since), 32'd1);
      seen_start = 1; done_since = 0;
    end
    if (rst_n) begin
      if (m_busy && !m_start && tx_done_tick) done_since = 1;
      m_launch = (m_q.size() > 0) && (!m_busy || (!m_start && tx_done_tick));
      m_acc    = wr_en && (m_q.size() < DEPTH);
      m_ovf    = wr_en && (m_q.size() == DEPTH);
      if (m_launch) m_din = m_q.pop_front();
      if (m_acc) m_q.push_back(wr_data);
      m_nbusy = m_launch || m_start || (m_busy && !tx_done_tick);
      m_start = m_launch;
      m_busy  = m_nbusy;
    end
  end

  // Stimulus side: transmitter emulation and independent accepted-byte log.
  int         xmit_cnt = -1;
  int         launch_after_done = 0;
  logic [7:0] accepted[$];

  task automatic tick(input bit w, input logic [7:0] d, input bit dn);
    wr_en = w; wr_data = d; tx_done_tick = dn;
    @(posedge clk);
    #1;
    wr_en = 0; wr_data = '0; tx_done_tick = 0;
  endtask

  task automatic run_cycle(input bit w, input logic [7:0] d, input int lo, input int hi,
                           input bit stray_ok);
    bit dn;
    dn = (xmit_cnt == 0);
    if (!dn && stray_ok && !busy && $urandom_range(0, 15) == 0) dn = 1;
    if (w && !full) accepted.push_back(d);
    tick(w, d, dn);
    if (xmit_cnt >= 0) xmit_cnt--;
    if (tx_start) begin
      xmit_cnt = $urandom_range(lo, hi);
      if (dn) launch_after_done++;
    end
  endtask

  task automatic drain(input int lo, input int hi);
    int n;
    n = 0;
    while (!(empty && !busy) && n < 3000) begin
      run_cycle(0, 8'h00, lo, hi, 0);
      n++;
    end
    if (n >= 3000) check("drain_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 0;
    #1;
    tick(0, 8'h00, 0);
    tick(0, 8'h00, 0);
    rst_n = 1;
    xmit_cnt = -1;
    launch_after_done = 0;
    launched.delete();
    accepted.delete();
  endtask

  task automatic compare_launched(input string name);
    check({name, "_count"}, 32'(launched.size()), 32'(accepted.size()));
    for (int i = 0; i < launched.size() && i < accepted.size(); i++)
      check({name, "_byte"}, 32'(launched[i]), 32'(accepted[i]));
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    do_reset();
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_busy",  32'(busy),  32'd0);
    check("rst_din",   32'(tx_din), 32'd0);

    // Single byte latency and busy window
    tick(1, 8'hA5, 0);
    check("t2_empty_n",   32'(empty),    32'd0);
    check("t2_start_n",   32'(tx_start), 32'd0);
    tick(0, 8'h00, 0);
    check("t2_start_n1",  32'(tx_start), 32'd1);
    check("t2_din",       32'(tx_din),   32'hA5);
    check("t2_empty_n1",  32'(empty),    32'd1);
    check("t2_busy",      32'(busy),     32'd1);
    tick(0, 8'h00, 0);
    check("t2_start_off", 32'(tx_start), 32'd0);
    check("t2_busy_wait", 32'(busy),     32'd1);
    tick(0, 8'h00, 1);
    check("t2_busy_done", 32'(busy),     32'd0);

    // Three bytes, each acked 20 cycles after launch
    do_reset();
    run_cycle(1, 8'h11, 20, 20, 0);
    run_cycle(1, 8'h22, 20, 20, 0);
    run_cycle(1, 8'h33, 20, 20, 0);
    drain(20, 20);
    check("t3_n",     32'(launched.size()), 32'd3);
    if (launched.size() == 3) begin
      check("t3_b0", 32'(launched[0]), 32'h11);
      check("t3_b1", 32'(launched[1]), 32'h22);
      check("t3_b2", 32'(launched[2]), 32'h33);
    end
    check("t3_b2b", 32'(launch_after_done), 32'd2);

    // Fill to full with acks held off, then overflow cases
    do_reset();
    for (int i = 0; i < 17; i++) tick(1, 8'(i), 0);
    check("t4_full",  32'(full),     32'd1);
    check("t4_ovf0",  32'(overflow), 32'd0);
    tick(1, 8'h99, 0);
    check("t4_ovf1",  32'(overflow), 32'd1);
    check("t4_full1", 32'(full),     32'd1);
    tick(1, 8'h77, 1);
    check("t4_ovf_pop",   32'(overflow), 32'd1);
    check("t4_full_pop",  32'(full),     32'd0);
    check("t4_start_pop", 32'(tx_start), 32'd1);
    check("t4_din_pop",   32'(tx_din),   32'h01);
    xmit_cnt = 3;
    drain(1, 4);
    check("t4_n", 32'(launched.size()), 32'd17);
    for (int i = 0; i < 17 && i < launched.size(); i++)
      check("t4_order", 32'(launched[i]), 32'(i));

    // Random streaming with bursty pushes and random ack latency
    do_reset();
    for (int i = 0; i < 70; i++) begin
      while ($urandom_range(0, 99) >= 70) run_cycle(0, 8'h00, 1, 8, 1);
      run_cycle(1, 8'($urandom), 1, 8, 1);
    end
    drain(1, 8);
    compare_launched("t5_stream");

    // Stray ack in idle, level thresholds
    do_reset();
    tick(0, 8'h00, 1);
    check("t6_busy",  32'(busy),     32'd0);
    check("t6_start", 32'(tx_start), 32'd0);
    check("t6_empty", 32'(empty),    32'd1);
    for (int i = 0; i < 14; i++) tick(1, 8'(8'h40 + i), 0);
`ifdef UART_TX_FIFO_LEVEL_EN
    check("t6_level13", 32'(level),       32'd13);
    check("t6_af13",    32'(almost_full), 32'd0);
`endif
    tick(1, 8'h4E, 0);
`ifdef UART_TX_FIFO_LEVEL_EN
    check("t6_level14", 32'(level),       32'd14);
    check("t6_af14",    32'(almost_full), 32'd1);
`endif
    check("t6_full14",  32'(full),  32'd0);
    check("t6_empty14", 32'(empty), 32'd0);

    // Reset mid-WAIT with three bytes queued
    do_reset();
    for (int i = 0; i < 4; i++) tick(1, 8'(8'hC0 + i), 0);
    tick(0, 8'h00, 0);
    check("t1_busy_pre", 32'(busy), 32'd1);
    rst_n = 0;
    #1;
    check("t1_empty", 32'(empty),    32'd1);
    check("t1_busy",  32'(busy),     32'd0);
    check("t1_start", 32'(tx_start), 32'd0);
    check("t1_din",   32'(tx_din),   32'd0);
    tick(0, 8'h00, 0);
    rst_n = 1;
    tick(0, 8'h00, 0);
    tick(0, 8'h00, 0);
    check("t1_stay_empty", 32'(empty), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
